pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits (1..256).
REQ-002 Parameter CLEAR_VAL, {WIDTH{1'b0}}, payload value loaded on reset/flush.
REQ-003 Parameter CNT_W, 16, width of each statistics counter (2..32).
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  upstream payload valid.
REQ-007 Port in_ready  output  1  block can accept payload this cycle.
REQ-008 Port in_data  input  WIDTH  upstream payload.
REQ-009 Port out_valid  output  1  downstream payload valid.
REQ-010 Port out_ready  input  1  downstream accepts payload this cycle.
REQ-011 Port out_data  output  WIDTH  downstream payload.
REQ-012 Port flush  input  1  synchronous kill of all held payloads (exception/Req).
REQ-013 Port cnt_clr  input  1  synchronous clear of statistics counters.
REQ-014 Port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
REQ-015 Port xfer_cnt  output  CNT_W  completed output transfers, wrapping.
REQ-016 Port flush_cnt  output  CNT_W  flush cycles that discarded at least one valid entry, saturating.

Function
REQ-017 Storage SHALL be two entries: main (drives out_data) and skid; state SHALL be one of EMPTY, ONE (main full), TWO (main and skid full).
REQ-018 out_valid SHALL be 1 exactly in ONE and TWO; out_data SHALL equal main payload.
REQ-019 in_ready SHALL be 1 exactly in EMPTY and ONE, derived from registered state only (no combinational path from out_ready or in_valid).
REQ-020 In-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready.
REQ-021 EMPTY: in-transfer -> ONE, main <= in_data; else stay EMPTY.
REQ-022 ONE: in & out -> ONE, main <= in_data; in only -> TWO, skid <= in_data; out only -> EMPTY; neither -> hold.
REQ-023 TWO: out-transfer -> ONE, main <= skid; else hold; no input accepted.
REQ-024 Latency SHALL be 1 cycle from in-transfer to out_valid when empty; throughput 1 payload/cycle while out_ready=1.
REQ-025 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush.
REQ-026 flush=1 SHALL, at the next edge, force EMPTY and load main and skid with CLEAR_VAL, overriding any simultaneous in- or out-transfer; the in-transfer that cycle is discarded.
REQ-027 An out-transfer in the same cycle as flush SHALL still count in xfer_cnt (downstream consumed it).
REQ-028 Payload registers not being loaded SHALL hold their values; skid content in EMPTY/ONE is don't-care but SHALL be CLEAR_VAL after reset/flush.
REQ-029 stall_cnt SHALL increment by 1 per cycle with out_valid & !out_ready and saturate at 2^CNT_W-1.
REQ-030 xfer_cnt SHALL increment per out-transfer and wrap from 2^CNT_W-1 to 0.
REQ-031 flush_cnt SHALL increment when flush=1 and state != EMPTY, saturating.
REQ-032 cnt_clr=1 SHALL zero all three counters at the next edge, taking priority over any increment that cycle; it SHALL not affect payload state.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for clk, force EMPTY, main=skid=CLEAR_VAL, all counters 0.
REQ-034 During reset: out_valid=0, in_ready=0 is not permitted; in_ready SHALL read 1 (state EMPTY).
REQ-035 Reset asserted mid-transfer SHALL discard all held payloads; first edge after deassertion behaves as from EMPTY.

Verification
REQ-036 Reset, then in_valid=1 data 0xA5A5_0001, out_ready=1 -> out_valid=1, out_data=0xA5A5_0001 one edge later; xfer_cnt=1 after next edge.
REQ-037 out_ready=0, push 0x11 then 0x22 -> state TWO, in_ready=0, out_data=0x11; third push 0x33 refused; release out_ready -> outputs 0x11, 0x22 on consecutive cycles, stall_cnt = stalled cycles.
REQ-038 In TWO (0x11, 0x22) assert flush with in_valid=1 data 0x44 -> next edge out_valid=0, out_data=CLEAR_VAL, 0x44 never appears, flush_cnt=1.
REQ-039 Hold out_ready=0 with ONE for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt stops at 15; cnt_clr=1 -> all counters 0 next edge.
REQ-040 Stream 20 random payloads, random in_valid/out_ready, WIDTH=8 -> output sequence equals input sequence, xfer_cnt=20.
REQ-041 Assert reset asynchronously between edges while TWO -> out_valid drops to 0 before next edge, in_ready=1.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register slice with flush and statistics counters
// in_ready is driven only from registered state, so out_ready has no combinational path to it.
module pipe_skid_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     CLEAR_VAL = {WIDTH{1'b0}},
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state == ONE) || (state == TWO);
  assign in_ready  = (state == EMPTY) || (state == ONE);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= CLEAR_VAL;
      skid_q <= CLEAR_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= CLEAR_VAL;
      skid_q <= CLEAR_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q <= in_data;
              state  <= TWO;
            end
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Counters observe the handshake regardless of flush; cnt_clr wins over every increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (out_xfer)
        xfer_cnt <= xfer_cnt + 1'b1;
      if (flush && (state != EMPTY) && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

  localparam logic [31:0] CLR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt, xfer_cnt, flush_cnt;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, flush8 = 1'b0, cnt_clr8 = 1'b0;
  logic [7:0]  in_data8 = '0;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_data8;
  logic [15:0] stall_cnt8, xfer_cnt8, flush_cnt8;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [7:0]  sb8[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .CLEAR_VAL(CLR), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt), .flush_cnt(flush_cnt)
  );

  pipe_skid_reg #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .flush(flush8),
    .cnt_clr(cnt_clr8), .stall_cnt(stall_cnt8), .xfer_cnt(xfer_cnt8), .flush_cnt(flush_cnt8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== CLR) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b in_ready=%b out_data=%h, required 0 1 %h",
               out_valid, in_ready, out_data, CLR);
    end
    checks++;
    if (stall_cnt !== 4'd0 || xfer_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters: %0d %0d %0d, required 0 0 0", stall_cnt, xfer_cnt, flush_cnt);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL basic_latency: out_valid=%b out_data=%h, required 1 a5a50001", out_valid, out_data);
    end
    step();
    checks++;
    if (xfer_cnt !== 4'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_xfer: xfer_cnt=%0d out_valid=%b, required 1 0", xfer_cnt, out_valid);
    end
    idle();
  endtask

  task automatic test_skid();
    cnt_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    cnt_clr = 1'b0; in_data = 32'h22;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin
      failures++;
      $display("FAIL skid_two: in_ready=%b out_valid=%b out_data=%h, required 0 1 11",
               in_ready, out_valid, out_data);
    end
    in_data = 32'h33;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_data !== 32'h11) begin
      failures++;
      $display("FAIL skid_first: out_data=%h, required 11", out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h22) begin
      failures++;
      $display("FAIL skid_second: out_valid=%b out_data=%h, required 1 22", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd2 || xfer_cnt !== 4'd2) begin
      failures++;
      $display("FAIL skid_drain: out_valid=%b stall=%0d xfer=%0d, required 0 2 2",
               out_valid, stall_cnt, xfer_cnt);
    end
    idle();
  endtask

  task automatic test_flush();
    cnt_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    cnt_clr = 1'b0; in_data = 32'h22;
    step();
    flush = 1'b1; in_data = 32'h44;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== CLR || in_ready !== 1'b1 || flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL flush_two: out_valid=%b out_data=%h in_ready=%b flush_cnt=%0d, required 0 %h 1 1",
               out_valid, out_data, in_ready, flush_cnt, CLR);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL flush_empty: out_valid=%b flush_cnt=%0d, required 0 1", out_valid, flush_cnt);
    end
    in_valid = 1'b1; in_data = 32'h66;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    step();
    idle();
    checks++;
    if (xfer_cnt !== 4'd1 || flush_cnt !== 4'd2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_with_xfer: xfer=%0d flush_cnt=%0d out_valid=%b, required 1 2 0",
               xfer_cnt, flush_cnt, out_valid);
    end
  endtask

  task automatic test_stall_sat();
    cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    step();
    cnt_clr = 1'b0; in_valid = 1'b0;
    repeat (19) step();
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL stall_saturate: stall_cnt=%0d, required 15", stall_cnt);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0 || xfer_cnt !== 4'd0 || flush_cnt !== 4'd0 ||
        out_valid !== 1'b1 || out_data !== 32'h77) begin
      failures++;
      $display("FAIL cnt_clr: %0d %0d %0d out_valid=%b out_data=%h, required 0 0 0 1 77",
               stall_cnt, xfer_cnt, flush_cnt, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && got < 17; i++) begin
      in_valid = (i < 17);
      in_data = 32'h1000 + i;
      #4;
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          failures++;
          $display("FAIL b2b_data: out_data=%h, required %h", out_data, (sb.size() != 0) ? sb[0] : 32'hx);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        got++;
      end
      step();
    end
    idle();
    checks++;
    if (got !== 17 || xfer_cnt !== 4'd1) begin
      failures++;
      $display("FAIL b2b_wrap: outputs=%0d xfer_cnt=%0d, required 17 1", got, xfer_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] pay[20];
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
    while (got < 20 && cyc < 2000) begin
      in_valid8  = (sent < 20) && ($urandom_range(0, 2) != 0);
      in_data8   = (sent < 20) ? pay[sent] : 8'h00;
      out_ready8 = ($urandom_range(0, 2) != 0);
      #4;
      if (in_valid8 && in_ready8) begin
        sb8.push_back(in_data8);
        sent++;
      end
      if (out_valid8 && out_ready8) begin
        checks++;
        if (sb8.size() == 0 || out_data8 !== sb8[0]) begin
          failures++;
          $display("FAIL rand_data: out_data=%h, required %h", out_data8, (sb8.size() != 0) ? sb8[0] : 8'hx);
        end
        if (sb8.size() != 0) void'(sb8.pop_front());
        got++;
      end
      step();
      cyc++;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    checks++;
    if (got !== 20 || xfer_cnt8 !== 16'd20) begin
      failures++;
      $display("FAIL rand_count: outputs=%0d xfer_cnt=%0d, required 20 20", got, xfer_cnt8);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== CLR) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%h, required 0 1 %h",
               out_valid, in_ready, out_data, CLR);
    end
    #2;
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: out_valid=%b out_data=%h in_ready=%b, required 1 55 1",
               out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_stall_sat();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
